// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// APB slave with a 64 x 8-bit register file. The slave sits downstream of an
// APB master and answers its select / enable / write strobes. Each transfer
// inserts a programmable number of wait states before PREADY rises. Transfers
// aimed at another slave (PADDR[6] != SLAVE_SEL) or writes into the read-only
// upper window (word address >= RO_BASE) complete with PSLVERR set and have no
// effect on memory. A sticky proto_err flag records protocol violations, and
// xfer_count counts every completed transfer, including errored ones.
//
// Parameters:
//   WAIT_STATES  access-phase cycles with PREADY low before PREADY rises (0..15)
//   SLAVE_SEL    value of PADDR[6] owned by this instance
//   RO_BASE      first read-only word address
//
// Ports:
//   PCLK        in   1  clock, all logic on the rising edge
//   PRESET      in   1  synchronous active-high reset
//   PSEL        in   1  slave select from the master
//   PENABLE     in   1  access-phase strobe
//   PWRITE      in   1  1 = write, 0 = read
//   PADDR       in   7  [6] slave-select bit, [5:0] word address
//   PWDATA      in   8  write data
//   PRDATA      out  8  read data, non-zero only in the PREADY cycle of a read
//   PREADY      out  1  transfer-complete handshake
//   PSLVERR     out  1  slave error, only ever high together with PREADY
//   proto_err   out  1  sticky protocol-violation flag, cleared only by reset
//   xfer_count  out  8  completed-transfer counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic        SLAVE_SEL   = 1'b1,
  parameter logic [5:0]  RO_BASE     = 6'd48
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [6:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       proto_err,
  output logic [7:0] xfer_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // The wait counter is 4 bits wide, so WAIT_STATES is meaningful in 0..15.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t     state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic [5:0] addr_q, addr_d;
  logic       write_q, write_d;
  logic [7:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic [7:0] readData_q, readData_d;
  logic       protoErr_q, protoErr_d;
  logic [7:0] xferCount_q, xferCount_d;

  logic [7:0] mem_q [64];
  logic       memWe;

  logic       ready;
  logic       setupErr;
  logic [7:0] setupRead;

  // Error classification and read data are both decided from the live bus in
  // the setup cycle. Only these latched copies are used afterwards, so any
  // movement on PADDR / PWRITE / PWDATA during the access phase is ignored.
  // Reading memory at setup time is safe for write-then-read sequences: the
  // write commits on the completion edge, one edge before the next setup.
  always_comb begin
    setupErr  = (PADDR[6] != SLAVE_SEL) | (PWRITE & (PADDR[5:0] >= RO_BASE));
    setupRead = 8'h00;
    if (!PWRITE && !setupErr) begin
      setupRead = mem_q[PADDR[5:0]];
    end
  end

  // PREADY is purely a function of registered state, which keeps it free of
  // combinational paths from the bus inputs.
  always_comb begin
    ready = (state_q == ACCESS) && (waitCnt_q == 4'd0);
  end

  // Next-state logic for the IDLE / ACCESS handshake. Everything holds by
  // default. A setup phase (PSEL=1, PENABLE=0) always re-latches the request
  // and restarts the wait counter. In ACCESS this also happens when the
  // master restarts a transfer without finishing it; that restart is flagged
  // as a protocol error but the new request is still served. Dropping PSEL
  // mid-transfer abandons the request without touching memory or the
  // transfer counter. The memory write itself is requested here and
  // performed by the memory process so both see the same completion condition.
  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    readData_d  = readData_q;
    protoErr_d  = protoErr_q;
    xferCount_d = xferCount_q;
    memWe       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_d     = PADDR[5:0];
          write_d    = PWRITE;
          wdata_d    = PWDATA;
          err_d      = setupErr;
          readData_d = setupRead;
          waitCnt_d  = WAIT_INIT;
          state_d    = ACCESS;
        end else if (PSEL && PENABLE) begin
          protoErr_d = 1'b1;
        end
      end

      ACCESS: begin
        if (!PSEL) begin
          protoErr_d = 1'b1;
          state_d    = IDLE;
        end else if (!PENABLE) begin
          protoErr_d = 1'b1;
          addr_d     = PADDR[5:0];
          write_d    = PWRITE;
          wdata_d    = PWDATA;
          err_d      = setupErr;
          readData_d = setupRead;
          waitCnt_d  = WAIT_INIT;
        end else if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else begin
          memWe       = write_q & ~err_q;
          xferCount_d = xferCount_q + 8'd1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and status registers. Reset is synchronous and takes priority
  // over any transfer in progress.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      waitCnt_q   <= 4'd0;
      addr_q      <= 6'd0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      err_q       <= 1'b0;
      readData_q  <= 8'h00;
      protoErr_q  <= 1'b0;
      xferCount_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      readData_q  <= readData_d;
      protoErr_q  <= protoErr_d;
      xferCount_q <= xferCount_d;
    end
  end

  // Register file. Reset clears every word, and because reset wins, a write
  // that would complete on a reset edge is dropped.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (memWe) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // Bus outputs are gated by PREADY so that read data and the slave error are
  // only visible in the completion cycle. Writes always present zero data.
  always_comb begin
    PREADY     = ready;
    PRDATA     = (ready && !write_q) ? readData_q : 8'h00;
    PSLVERR    = err_q & ready;
    proto_err  = protoErr_q;
    xfer_count = xferCount_q;
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Two slave instances share clock and reset: dutA with one wait state and
// dutB with none. Stimulus tasks push the expected completion response into a
// scoreboard queue; a monitor on the falling edge pops it whenever either
// slave raises PREADY and compares PRDATA / PSLVERR. Status outputs, latency
// and reset behaviour are compared directly by the stimulus thread.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_apb_mem_slave;

  localparam int WS_A = 1;
  localparam int WS_B = 0;

  typedef struct packed {
    logic        dut;
    logic [7:0]  rdata;
    logic        slvErr;
    logic [15:0] tag;
  } expect_t;

  logic clock = 1'b0;
  logic reset;

  logic [1:0] sel;
  logic [1:0] en;
  logic [1:0] wr;
  logic [6:0] addr [2];
  logic [7:0] wdata [2];

  logic [7:0] rdataA, rdataB;
  logic [7:0] xferA, xferB;
  logic       readyA, readyB;
  logic       slvErrA, slvErrB;
  logic       protoA, protoB;

  int      checks = 0;
  int      passes = 0;
  int      cycle = 0;
  int      tagCount = 0;
  logic    monitorOn = 1'b0;
  expect_t expQ[$];
  expect_t monE;

  // Free-running clock and a cycle counter used to measure transfer length.
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cycle <= cycle + 1;
  end

  apb_mem_slave #(
    .WAIT_STATES(WS_A),
    .SLAVE_SEL  (1'b1),
    .RO_BASE    (6'd48)
  ) dutA (
    .PCLK      (clock),
    .PRESET    (reset),
    .PSEL      (sel[0]),
    .PENABLE   (en[0]),
    .PWRITE    (wr[0]),
    .PADDR     (addr[0]),
    .PWDATA    (wdata[0]),
    .PRDATA    (rdataA),
    .PREADY    (readyA),
    .PSLVERR   (slvErrA),
    .proto_err (protoA),
    .xfer_count(xferA)
  );

  apb_mem_slave #(
    .WAIT_STATES(WS_B),
    .SLAVE_SEL  (1'b1),
    .RO_BASE    (6'd48)
  ) dutB (
    .PCLK      (clock),
    .PRESET    (reset),
    .PSEL      (sel[1]),
    .PENABLE   (en[1]),
    .PWRITE    (wr[1]),
    .PADDR     (addr[1]),
    .PWDATA    (wdata[1]),
    .PRDATA    (rdataB),
    .PREADY    (readyB),
    .PSLVERR   (slvErrB),
    .proto_err (protoB),
    .xfer_count(xferB)
  );

  function automatic logic getReady(input int d);
    return (d == 0) ? readyA : readyB;
  endfunction

  function automatic logic [7:0] getRdata(input int d);
    return (d == 0) ? rdataA : rdataB;
  endfunction

  function automatic logic getSlvErr(input int d);
    return (d == 0) ? slvErrA : slvErrB;
  endfunction

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: any PREADY must match the oldest pending expectation,
  // which must also belong to the slave that raised PREADY.
  always @(negedge clock) begin
    if (monitorOn) begin
      for (int d = 0; d < 2; d++) begin
        if (getReady(d)) begin
          if (expQ.size() == 0 || expQ[0].dut != 1'(d)) begin
            checkOutput($sformatf("unexpected PREADY dut%0d", d),
                        32'(getReady(d)), 32'd0);
          end else begin
            monE = expQ.pop_front();
            checkOutput($sformatf("xfer%0d PRDATA", monE.tag),
                        32'(getRdata(d)), 32'(monE.rdata));
            checkOutput($sformatf("xfer%0d PSLVERR", monE.tag),
                        32'(getSlvErr(d)), 32'(monE.slvErr));
          end
        end
      end
    end
  end

  // Hold reset for n edges with both buses parked.
  task automatic applyReset(input int n);
    reset = 1'b1;
    sel   = 2'b00;
    en    = 2'b00;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
  endtask

  // One complete APB transfer on slave d. Bus fields are scrambled during the
  // access phase since the slave must only use the values seen at setup.
  task automatic applyStimulus(input int d, input logic write, input logic [6:0] a,
                               input logic [7:0] wd, input logic [7:0] expRdata,
                               input logic expErr, input int expLatency);
    expect_t e;
    int      lat;
    e.dut    = 1'(d);
    e.rdata  = expRdata;
    e.slvErr = expErr;
    e.tag    = 16'(tagCount);
    tagCount++;
    expQ.push_back(e);

    sel[d]   = 1'b1;
    en[d]    = 1'b0;
    wr[d]    = write;
    addr[d]  = a;
    wdata[d] = wd;
    @(posedge clock);
    #1;
    en[d]    = 1'b1;
    wr[d]    = ~write;
    addr[d]  = ~a;
    wdata[d] = ~wd;
    lat = 1;
    while (!getReady(d) && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput($sformatf("xfer%0d latency", e.tag), 32'(lat), 32'(expLatency));
    @(posedge clock);
    #1;
    sel[d] = 1'b0;
    en[d]  = 1'b0;
  endtask

  // Setup a write, then drop PSEL during the first access cycle.
  task automatic applyAbort(input int d, input logic [6:0] a, input logic [7:0] wd);
    sel[d]   = 1'b1;
    en[d]    = 1'b0;
    wr[d]    = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    @(posedge clock);
    #1;
    sel[d] = 1'b0;
    en[d]  = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    expect_t e;
    int      c0;

    reset    = 1'b1;
    sel      = 2'b00;
    en       = 2'b00;
    wr       = 2'b00;
    addr[0]  = 7'h00;
    addr[1]  = 7'h00;
    wdata[0] = 8'h00;
    wdata[1] = 8'h00;

    applyReset(2);
    monitorOn = 1'b1;
    checkOutput("reset PRDATA", 32'(rdataA), 32'd0);
    checkOutput("reset PREADY", 32'(readyA), 32'd0);
    checkOutput("reset PSLVERR", 32'(slvErrA), 32'd0);
    checkOutput("reset proto_err", 32'(protoA), 32'd0);
    checkOutput("reset xfer_count", 32'(xferA), 32'd0);
    checkOutput("reset xfer_count B", 32'(xferB), 32'd0);

    $display("[TB] write then read, one wait state");
    applyStimulus(0, 1'b1, 7'h45, 8'hA5, 8'h00, 1'b0, 2);
    checkOutput("xfer_count after write", 32'(xferA), 32'd1);
    applyStimulus(0, 1'b0, 7'h45, 8'h00, 8'hA5, 1'b0, 2);

    $display("[TB] back-to-back, zero wait states");
    c0 = cycle;
    applyStimulus(1, 1'b1, 7'h40, 8'h11, 8'h00, 1'b0, 1);
    applyStimulus(1, 1'b1, 7'h41, 8'h22, 8'h00, 1'b0, 1);
    applyStimulus(1, 1'b0, 7'h40, 8'h00, 8'h11, 1'b0, 1);
    applyStimulus(1, 1'b0, 7'h41, 8'h00, 8'h22, 1'b0, 1);
    checkOutput("back-to-back cycles", 32'(cycle - c0), 32'd8);
    checkOutput("xfer_count B", 32'(xferB), 32'd4);

    $display("[TB] slave errors");
    applyStimulus(0, 1'b1, 7'h05, 8'h33, 8'h00, 1'b1, 2);
    applyStimulus(0, 1'b0, 7'h45, 8'h00, 8'hA5, 1'b0, 2);
    applyStimulus(0, 1'b1, 7'h70, 8'hFF, 8'h00, 1'b1, 2);
    applyStimulus(0, 1'b0, 7'h70, 8'h00, 8'h00, 1'b0, 2);
    applyStimulus(0, 1'b0, 7'h05, 8'h00, 8'h00, 1'b1, 2);
    checkOutput("xfer_count after errors", 32'(xferA), 32'd7);
    checkOutput("proto_err after errors", 32'(protoA), 32'd0);

    $display("[TB] abort");
    applyAbort(0, 7'h42, 8'h5A);
    checkOutput("proto_err after abort", 32'(protoA), 32'd1);
    checkOutput("xfer_count after abort", 32'(xferA), 32'd7);
    applyStimulus(0, 1'b0, 7'h42, 8'h00, 8'h00, 1'b0, 2);
    checkOutput("xfer_count after read", 32'(xferA), 32'd8);
    checkOutput("proto_err sticky", 32'(protoA), 32'd1);

    $display("[TB] enable without setup");
    applyReset(2);
    checkOutput("proto_err cleared", 32'(protoA), 32'd0);
    sel[0] = 1'b1;
    en[0]  = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("idle violation proto_err", 32'(protoA), 32'd1);
    checkOutput("idle violation PREADY", 32'(readyA), 32'd0);
    sel[0] = 1'b0;
    en[0]  = 1'b0;
    @(posedge clock);
    #1;

    $display("[TB] reset during completion of a write");
    e.dut    = 1'b0;
    e.rdata  = 8'h00;
    e.slvErr = 1'b0;
    e.tag    = 16'(tagCount);
    tagCount++;
    expQ.push_back(e);
    sel[0]   = 1'b1;
    en[0]    = 1'b0;
    wr[0]    = 1'b1;
    addr[0]  = 7'h43;
    wdata[0] = 8'h77;
    @(posedge clock);
    #1;
    en[0] = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("pre-reset PREADY", 32'(readyA), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset  = 1'b0;
    sel[0] = 1'b0;
    en[0]  = 1'b0;
    checkOutput("mid reset PRDATA", 32'(rdataA), 32'd0);
    checkOutput("mid reset PREADY", 32'(readyA), 32'd0);
    checkOutput("mid reset PSLVERR", 32'(slvErrA), 32'd0);
    checkOutput("mid reset proto_err", 32'(protoA), 32'd0);
    checkOutput("mid reset xfer_count", 32'(xferA), 32'd0);
    applyStimulus(0, 1'b0, 7'h43, 8'h00, 8'h00, 1'b0, 2);
    checkOutput("xfer_count after reset read", 32'(xferA), 32'd1);

    $display("[TB] counter wrap");
    applyReset(1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(0, 1'b0, 7'h40, 8'h00, 8'h00, 1'b0, 2);
      if (i == 254) begin
        checkOutput("xfer_count at 255", 32'(xferA), 32'd255);
      end
    end
    checkOutput("xfer_count wrapped", 32'(xferA), 32'd0);

    @(negedge clock);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
